// File: rtl/pong_avm_pkg.sv
// Shared types and helpers for the Pong score Avalon-MM initiator.
package pong_avm_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CMP  = 2'd3
    } state_t;

    // Only the low two byte lanes carry the 16-bit hex-digit register
    localparam logic [3:0] HEX_PIO_BYTEEN = 4'b0011;

    // Left score occupies the upper digit pair, right score the lower pair
    function automatic logic [15:0] pack_score(input logic [7:0] left, input logic [7:0] right);
        return {left, right};
    endfunction

endpackage

// File: rtl/pong_score_avm_master.sv
// Avalon-MM initiator that writes packed Pong scores into the hex-digit PIO,
// reads the register back to verify it, retries on mismatch and coalesces
// score updates that arrive while a transaction is in flight.
module pong_score_avm_master
    import pong_avm_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = {ADDR_W{1'b0}},
    parameter int unsigned         MAX_RETRY = 3,
    parameter bit                  SKIP_DUP  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              score_valid,
    input  logic [7:0]        score_left,
    input  logic [7:0]        score_right,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    // Retry limit folded into the counter width (legal range 0..7)
    localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

    // Registered state
    state_t             r_state;
    logic               r_avm_read;
    logic               r_avm_write;
    logic [31:0]        r_avm_writedata;
    logic [ADDR_W-1:0]  r_avm_address;
    logic [3:0]         r_avm_byteenable;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [15:0]        r_cur_word;
    logic [15:0]        r_last_word;
    logic               r_last_valid;
    logic [15:0]        r_pend_word;
    logic               r_pend_flag;
    logic [2:0]         r_retry_cnt;
    logic [15:0]        r_rd_word;

    // Next-state values
    state_t             w_nxt_state;
    logic               w_nxt_read;
    logic               w_nxt_write;
    logic [31:0]        w_nxt_writedata;
    logic               w_nxt_done;
    logic               w_nxt_error;
    logic [15:0]        w_nxt_cur_word;
    logic [15:0]        w_nxt_last_word;
    logic               w_nxt_last_valid;
    logic [15:0]        w_nxt_pend_word;
    logic               w_nxt_pend_flag;
    logic [2:0]         w_nxt_retry_cnt;
    logic [15:0]        w_nxt_rd_word;

    // Helpers
    logic [15:0]        w_new_word;
    logic [15:0]        w_take_word;
    logic               w_has_next;
    logic               w_match;
    logic               w_unused_rd;

    // The PIO is 16 bits wide; the upper readback lanes carry nothing useful
    assign w_unused_rd = ^avm_readdata[31:16];

    // Next-state and registered-output decode; defaults hold every register
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_read       = r_avm_read;
        w_nxt_write      = r_avm_write;
        w_nxt_writedata  = r_avm_writedata;
        w_nxt_done       = 1'b0;
        w_nxt_error      = r_error;
        w_nxt_cur_word   = r_cur_word;
        w_nxt_last_word  = r_last_word;
        w_nxt_last_valid = r_last_valid;
        w_nxt_pend_word  = r_pend_word;
        w_nxt_pend_flag  = r_pend_flag;
        w_nxt_retry_cnt  = r_retry_cnt;
        w_nxt_rd_word    = r_rd_word;

        w_new_word  = pack_score(score_left, score_right);
        // A fresh strobe always beats an older pending word
        w_take_word = score_valid ? w_new_word : r_pend_word;
        w_has_next  = score_valid | r_pend_flag;
        w_match     = (r_rd_word == r_cur_word);

        case (r_state)
            IDLE: begin
                w_nxt_read  = 1'b0;
                w_nxt_write = 1'b0;
                if (w_has_next) begin
                    w_nxt_pend_flag = 1'b0;
                    w_nxt_cur_word  = w_take_word;
                    w_nxt_retry_cnt = 3'd0;
                    if (SKIP_DUP && r_last_valid && (w_take_word == r_last_word)) begin
                        w_nxt_state = IDLE;
                    end else begin
                        w_nxt_state     = WR;
                        w_nxt_write     = 1'b1;
                        w_nxt_writedata = {16'h0000, w_take_word};
                    end
                end else begin
                    w_nxt_state = IDLE;
                end
            end

            WR: begin
                if (score_valid) begin
                    w_nxt_pend_word = w_new_word;
                    w_nxt_pend_flag = 1'b1;
                end else begin
                    w_nxt_pend_flag = r_pend_flag;
                end
                if (r_avm_write && !avm_waitrequest) begin
                    w_nxt_write = 1'b0;
                    w_nxt_read  = 1'b1;
                    w_nxt_state = RD;
                end else begin
                    w_nxt_write = 1'b1;
                end
            end

            RD: begin
                if (score_valid) begin
                    w_nxt_pend_word = w_new_word;
                    w_nxt_pend_flag = 1'b1;
                end else begin
                    w_nxt_pend_flag = r_pend_flag;
                end
                if (r_avm_read && !avm_waitrequest) begin
                    w_nxt_read    = 1'b0;
                    w_nxt_rd_word = avm_readdata[15:0];
                    w_nxt_state   = CMP;
                end else begin
                    w_nxt_read = 1'b1;
                end
            end

            CMP: begin
                if (w_match) begin
                    w_nxt_last_word  = r_cur_word;
                    w_nxt_last_valid = 1'b1;
                    w_nxt_done       = 1'b1;
                    if (w_has_next) begin
                        w_nxt_pend_flag = 1'b0;
                        w_nxt_cur_word  = w_take_word;
                        w_nxt_retry_cnt = 3'd0;
                        w_nxt_writedata = {16'h0000, w_take_word};
                        w_nxt_write     = 1'b1;
                        w_nxt_state     = WR;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end else if (r_retry_cnt < MAX_RETRY_C) begin
                    // Same word again; a strobe arriving now is parked as pending
                    w_nxt_retry_cnt = r_retry_cnt + 3'd1;
                    w_nxt_writedata = {16'h0000, r_cur_word};
                    w_nxt_write     = 1'b1;
                    w_nxt_state     = WR;
                    if (score_valid) begin
                        w_nxt_pend_word = w_new_word;
                        w_nxt_pend_flag = 1'b1;
                    end else begin
                        w_nxt_pend_flag = r_pend_flag;
                    end
                end else begin
                    w_nxt_error = 1'b1;
                    if (w_has_next) begin
                        w_nxt_pend_flag = 1'b0;
                        w_nxt_cur_word  = w_take_word;
                        w_nxt_retry_cnt = 3'd0;
                        w_nxt_writedata = {16'h0000, w_take_word};
                        w_nxt_write     = 1'b1;
                        w_nxt_state     = WR;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end
            end

            default: begin
                w_nxt_read  = 1'b0;
                w_nxt_write = 1'b0;
                w_nxt_state = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight or pending update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_writedata  <= 32'h0000_0000;
            r_avm_address    <= BASE_ADDR;
            r_avm_byteenable <= HEX_PIO_BYTEEN;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_cur_word       <= 16'h0000;
            r_last_word      <= 16'h0000;
            r_last_valid     <= 1'b0;
            r_pend_word      <= 16'h0000;
            r_pend_flag      <= 1'b0;
            r_retry_cnt      <= 3'd0;
            r_rd_word        <= 16'h0000;
        end else begin
            r_state          <= w_nxt_state;
            r_avm_read       <= w_nxt_read;
            r_avm_write      <= w_nxt_write;
            r_avm_writedata  <= w_nxt_writedata;
            r_avm_address    <= BASE_ADDR;
            r_avm_byteenable <= HEX_PIO_BYTEEN;
            r_busy           <= (w_nxt_state != IDLE);
            r_done           <= w_nxt_done;
            r_error          <= w_nxt_error;
            r_cur_word       <= w_nxt_cur_word;
            r_last_word      <= w_nxt_last_word;
            r_last_valid     <= w_nxt_last_valid;
            r_pend_word      <= w_nxt_pend_word;
            r_pend_flag      <= w_nxt_pend_flag;
            r_retry_cnt      <= w_nxt_retry_cnt;
            r_rd_word        <= w_nxt_rd_word;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_writedata  = r_avm_writedata;
    assign avm_byteenable = r_avm_byteenable;

endmodule

// File: tb/tb_pong_score_avm_master.sv
// Directed bench for pong_score_avm_master: table of single updates plus
// hand-written sequences for timing, coalescing and reset.
module tb_pong_score_avm_master;

    logic        clk;
    logic        reset_n;
    logic        score_valid;
    logic [7:0]  score_left;
    logic [7:0]  score_right;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    pong_score_avm_master #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0000_0000),
        .MAX_RETRY (3),
        .SKIP_DUP  (1'b1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .score_valid     (score_valid),
        .score_left      (score_left),
        .score_right     (score_right),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    int          wr_stall;
    int          rd_stall;
    int          s_stall;
    logic        s_bad;
    logic [15:0] s_mem;

    assign avm_waitrequest = (avm_write && (s_stall < wr_stall)) || (avm_read && (s_stall < rd_stall));
    assign avm_readdata    = s_bad ? 32'h0000_FFFF : {16'h0000, s_mem};

    // Stall counter and the PIO register itself
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_stall <= 0;
        end else begin
            if (avm_write || avm_read) begin
                if (avm_waitrequest) s_stall <= s_stall + 1;
                else                 s_stall <= 0;
            end
            if (avm_write && !avm_waitrequest) s_mem <= avm_writedata[15:0];
        end
    end

    // ---------------- bus monitor ----------------
    int          n_wr;
    int          n_rd;
    int          n_done;
    int          n_viol;
    int          log_n;
    logic [15:0] wr_log [0:63];
    logic        prev_wst;
    logic        prev_rst;
    logic [31:0] prev_wdata;

    initial begin
        n_wr = 0; n_rd = 0; n_done = 0; n_viol = 0; log_n = 0;
        prev_wst = 1'b0; prev_rst = 1'b0; prev_wdata = 32'h0;
    end

    // Count accepted requests and done pulses; flag protocol violations
    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_write && avm_read) n_viol <= n_viol + 1;
            if ((avm_write || avm_read) && (avm_address != 32'h0000_0000)) n_viol <= n_viol + 1;
            if (prev_wst && (!avm_write || (avm_writedata != prev_wdata))) n_viol <= n_viol + 1;
            if (prev_rst && !avm_read) n_viol <= n_viol + 1;
            if (avm_write && !avm_waitrequest) begin
                n_wr <= n_wr + 1;
                if (log_n < 64) begin
                    wr_log[log_n] <= avm_writedata[15:0];
                    log_n <= log_n + 1;
                end
            end
            if (avm_read && !avm_waitrequest) n_rd <= n_rd + 1;
            if (done) n_done <= n_done + 1;
            prev_wst   <= avm_write && avm_waitrequest;
            prev_rst   <= avm_read && avm_waitrequest;
            prev_wdata <= avm_writedata;
        end else begin
            prev_wst <= 1'b0;
            prev_rst <= 1'b0;
        end
    end

    // ---------------- checking helpers ----------------
    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] l, input logic [7:0] r);
        @(negedge clk);
        score_valid = 1'b1;
        score_left  = l;
        score_right = r;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && (k < 300)) begin
            @(negedge clk);
            k = k + 1;
        end
        check("idle_reached", {31'h0, busy}, 32'h0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  l;
        logic [7:0]  r;
        int          wst;
        int          rst;
        logic        bad_rd;
        int          exp_wr;
        int          exp_rd;
        int          exp_done;
        logic [15:0] exp_last;
        logic        exp_err;
    } vec_t;

    vec_t vt [0:7];

    initial begin
        int w0, r0, d0;

        total = 0; bad = 0;
        score_valid = 1'b0; score_left = 8'h00; score_right = 8'h00;
        wr_stall = 0; rd_stall = 0; s_bad = 1'b0;

        vt[0] = '{8'h12, 8'h34, 0, 0, 1'b0, 1, 1, 1, 16'h1234, 1'b0};
        vt[1] = '{8'h01, 8'h01, 4, 2, 1'b0, 1, 1, 1, 16'h0101, 1'b0};
        vt[2] = '{8'h05, 8'h05, 0, 0, 1'b0, 1, 1, 1, 16'h0505, 1'b0};
        vt[3] = '{8'h05, 8'h05, 0, 0, 1'b0, 0, 0, 0, 16'h0505, 1'b0};
        vt[4] = '{8'h05, 8'h06, 1, 1, 1'b0, 1, 1, 1, 16'h0506, 1'b0};
        vt[5] = '{8'h99, 8'h99, 0, 0, 1'b1, 4, 4, 0, 16'h9999, 1'b1};
        vt[6] = '{8'h99, 8'h99, 0, 0, 1'b0, 1, 1, 1, 16'h9999, 1'b1};
        vt[7] = '{8'h99, 8'h99, 0, 0, 1'b0, 0, 0, 0, 16'h9999, 1'b1};

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",   {31'h0, busy}, 32'h0);
        check("rst_done",   {31'h0, done}, 32'h0);
        check("rst_error",  {31'h0, error}, 32'h0);
        check("rst_read",   {31'h0, avm_read}, 32'h0);
        check("rst_write",  {31'h0, avm_write}, 32'h0);
        check("rst_wdata",  avm_writedata, 32'h0);
        check("rst_addr",   avm_address, 32'h0);
        check("rst_byteen", {28'h0, avm_byteenable}, 32'h3);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic write: cycle-exact timing
        strobe(8'h03, 8'h07);
        check("basic_write", {31'h0, avm_write}, 32'h1);
        check("basic_wdata", avm_writedata, 32'h0000_0307);
        check("basic_noread", {31'h0, avm_read}, 32'h0);
        @(negedge clk);
        check("basic_read", {31'h0, avm_read}, 32'h1);
        check("basic_wr_off", {31'h0, avm_write}, 32'h0);
        @(negedge clk);
        check("basic_cmp_nodone", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("basic_done", {31'h0, done}, 32'h1);
        check("basic_busy_low", {31'h0, busy}, 32'h0);
        wait_idle();

        // Table of single updates
        for (int i = 0; i < 8; i++) begin
            wr_stall = vt[i].wst;
            rd_stall = vt[i].rst;
            s_bad    = vt[i].bad_rd;
            w0 = n_wr; r0 = n_rd; d0 = n_done;
            strobe(vt[i].l, vt[i].r);
            wait_idle();
            check($sformatf("v%0d_writes", i), n_wr - w0, vt[i].exp_wr);
            check($sformatf("v%0d_reads", i),  n_rd - r0, vt[i].exp_rd);
            check($sformatf("v%0d_done", i),   n_done - d0, vt[i].exp_done);
            check($sformatf("v%0d_lastwr", i), {16'h0, wr_log[log_n - 1]}, {16'h0, vt[i].exp_last});
            check($sformatf("v%0d_error", i),  {31'h0, error}, {31'h0, vt[i].exp_err});
        end
        s_bad = 1'b0;

        // Coalescing: two strobes during a stalled write, only the newest survives
        wr_stall = 6; rd_stall = 2;
        w0 = n_wr; d0 = n_done;
        strobe(8'h01, 8'h01);
        strobe(8'h01, 8'h02);
        strobe(8'h01, 8'h03);
        wait_idle();
        check("coal_writes", n_wr - w0, 2);
        check("coal_done",   n_done - d0, 2);
        check("coal_first",  {16'h0, wr_log[log_n - 2]}, 32'h0101);
        check("coal_second", {16'h0, wr_log[log_n - 1]}, 32'h0103);

        // Reset mid-read, then the previously verified word must be written again
        wr_stall = 0; rd_stall = 0;
        strobe(8'h07, 8'h07);
        wait_idle();
        rd_stall = 1000;
        strobe(8'h08, 8'h08);
        repeat (3) @(negedge clk);
        check("pre_rst_read", {31'h0, avm_read}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("arst_read",   {31'h0, avm_read}, 32'h0);
        check("arst_write",  {31'h0, avm_write}, 32'h0);
        check("arst_busy",   {31'h0, busy}, 32'h0);
        check("arst_error",  {31'h0, error}, 32'h0);
        check("arst_wdata",  avm_writedata, 32'h0);
        check("arst_addr",   avm_address, 32'h0);
        check("arst_byteen", {28'h0, avm_byteenable}, 32'h3);
        @(negedge clk);
        reset_n = 1'b1;
        rd_stall = 0;
        w0 = n_wr; d0 = n_done;
        strobe(8'h07, 8'h07);
        wait_idle();
        check("post_rst_write", n_wr - w0, 1);
        check("post_rst_done",  n_done - d0, 1);
        check("post_rst_word",  {16'h0, wr_log[log_n - 1]}, 32'h0707);

        check("protocol_viol", n_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
